// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} spi_state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
  localparam int SPI_DATA_W = 8;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: HALF_DIV divider producing sck leading/trailing edge strobes
module spi_clk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic edge_en_i,
  output logic tick_o,
  output logic lead_edge_o,
  output logic trail_edge_o
);
  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  // divider wraps every HALF_DIV cycles; phase alternates leading/trailing edges
  always_comb begin
    tick_o  = en_i && (cnt_q == 8'(HALF_DIV - 1));
    cnt_d   = (!en_i || tick_o) ? 8'd0 : cnt_q + 8'd1;
    phase_d = !edge_en_i ? 1'b0 : (tick_o ? ~phase_q : phase_q);
  end
  assign lead_edge_o  = tick_o && edge_en_i && !phase_q;
  assign trail_edge_o = tick_o && edge_en_i && phase_q;
  // divider and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/spi_master.sv
// spi_master: single-frame SPI master with runtime cpol/cpha and registered pins
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_DIV = 2,
  parameter int DATA_W   = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic              ena,
  output logic              din,
  input  logic              dout
);
  localparam int BW = $clog2(DATA_W + 1);

  spi_state_t        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_nx;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              sck_q, sck_d;
  logic              ena_q, ena_d;
  logic              din_q, din_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tick, lead, trail;
  logic              accept, last, sample, shift_en;

  spi_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (state_q != IDLE),
    .edge_en_i    (state_q == SETUP || state_q == XFER),
    .tick_o       (tick),
    .lead_edge_o  (lead),
    .trail_edge_o (trail)
  );

  assign accept   = tx_valid && tx_ready_q;
  assign last     = trail && (bit_cnt_q == BW'(DATA_W - 1));
  assign sample   = mode_q.cpha ? trail : lead;
  assign shift_en = mode_q.cpha ? lead : (trail && !last);
  assign sh_nx    = sh_q << 1;

  // frame sequencing: the SETUP tick doubles as the first leading edge
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sh_d       = sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sck_d      = sck_q;
    ena_d      = ena_q;
    din_d      = din_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        sck_d      = cpol;
        tx_ready_d = 1'b1;
        if (accept) begin
          state_d    = SETUP;
          mode_d     = '{cpol: cpol, cpha: cpha};
          sh_d       = tx_data;
          rx_sh_d    = '0;
          bit_cnt_d  = '0;
          din_d      = tx_data[DATA_W-1];
          ena_d      = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      SETUP, XFER: begin
        if (lead || trail) sck_d = ~sck_q;
        if (sample) rx_sh_d = DATA_W'({rx_sh_q, dout});
        if (shift_en) begin
          sh_d  = sh_nx;
          din_d = mode_q.cpha ? sh_q[DATA_W-1] : sh_nx[DATA_W-1];
        end
        if (trail) bit_cnt_d = bit_cnt_q + BW'(1);
        if (state_q == SETUP && tick) state_d = XFER;
        if (last) state_d = HOLD;
      end
      HOLD: begin
        sck_d = mode_q.cpol;
        if (tick) begin
          state_d    = GAP;
          ena_d      = 1'b1;
          din_d      = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          tx_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      sh_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      sck_q      <= 1'b0;
      ena_q      <= 1'b1;
      din_q      <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sh_q       <= sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      sck_q      <= sck_d;
      ena_q      <= ena_d;
      din_q      <= din_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = state_q != IDLE;
  assign sck      = sck_q;
  assign ena      = ena_q;
  assign din      = din_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master with loopback and mode-0 slave
module tb_spi_master;
  logic       clk = 1'b0, rst_n = 1'b0, cpol = 1'b0, cpha = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, busy, sck, ena, din, dout;
  logic [7:0] rx_data;
  logic       use_loop = 1'b1;
  logic [7:0] sl_pat = 8'h00, sl = 8'h00, sl_rx = 8'h00;
  logic [7:0] exp_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, last_rx_cyc = 0, t1 = 0, rv = 0;

  spi_master #(.HALF_DIV(2), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpol     (cpol),
    .cpha     (cpha),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sck      (sck),
    .ena      (ena),
    .din      (din),
    .dout     (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode-0 slave: loads on select, shifts out on falling sck, captures on rising sck
  always @(negedge ena) sl <= sl_pat;
  always @(negedge sck) if (!ena) sl <= sl << 1;
  always @(posedge sck) if (!ena) sl_rx <= {sl_rx[6:0], din};
  assign dout = use_loop ? din : sl[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] tx, input logic pol, input logic pha, input logic lp,
                           input logic [7:0] pat, input int abort_at, input logic disturb);
    logic psck, pdin, ok, done;
    logic [7:0] mosi;
    int first_low, last_low, n_low, edges, bad, rv_n, rv_cnt, ready_n, gap;
    psck = 0; pdin = 0; ok = 0; done = 0; mosi = 0;
    first_low = 0; last_low = 0; n_low = 0; edges = 0; bad = 0;
    rv_n = 0; rv_cnt = 0; ready_n = 0; gap = 0;
    use_loop = lp; sl_pat = pat;
    tx_data = tx; cpol = pol; cpha = pha; tx_valid = 1'b1;
    if (abort_at == 0) exp_q.push_back(lp ? tx : pat);
    for (int w = 0; w < 100 && !ok; w++) begin
      if (tx_ready) ok = 1;
      else @(negedge clk);
    end
    chk("accept", ok, 1);
    @(posedge clk);
    for (int n = 1; n <= 100 && !done; n++) begin
      @(negedge clk);
      if (n == 1) begin
        tx_valid = 1'b0;
        chk("sck_idle", sck, pol);
        chk("din_msb", din, tx[7]);
      end
      if (disturb && n == 10) begin
        tx_data = ~tx; cpol = ~pol; cpha = ~pha; tx_valid = 1'b1;
      end
      if (disturb && n == 20) tx_valid = 1'b0;
      if (abort_at != 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_ena", ena, 1);
        chk("abort_sck", sck, 0);
        chk("abort_din", din, 0);
        chk("abort_ready", tx_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rxv", rx_valid, 0);
        return;
      end
      if (n > 1 && sck != psck) begin
        edges++;
        if ((psck == pol) ^ pha) mosi = {mosi[6:0], din};
      end
      if (n > 1 && !ena && din != pdin && !(sck != psck && ((psck == pol) ^ !pha))) bad++;
      if (!ena) begin
        if (first_low == 0) first_low = n;
        last_low = n;
        n_low++;
      end else if (first_low != 0) gap++;
      if (rx_valid) begin
        rv_cnt++;
        if (rv_cnt == 1) begin
          rv_n = n;
          last_rx_cyc = cyc;
          if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
          else chk("rx_data", rx_data, exp_q.pop_front());
        end
      end
      if (tx_ready) begin
        ready_n = n;
        done = 1;
      end
      psck = sck;
      pdin = din;
    end
    chk("ready_cycle", ready_n, 37);
    chk("ena_first", first_low, 1);
    chk("ena_last", last_low, 34);
    chk("ena_cnt", n_low, 34);
    chk("sck_edges", edges, 16);
    chk("din_timing", bad, 0);
    chk("mosi", mosi, tx);
    chk("rx_cycle", rv_n, 35);
    chk("rx_pulses", rv_cnt, 1);
    chk("ena_gap", gap >= 2, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 0);
    chk("rst_ena", ena, 1);
    chk("rst_sck", sck, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_post_rst", tx_ready, 1);
    @(negedge clk);
    run_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0);
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'hB2, 0, 1'b0);
    chk("slave_mosi", sl_rx, 8'h3C);
    run_frame(8'h81, 1'b1, 1'b1, 1'b1, 8'h00, 0, 1'b0);
    run_frame(8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0);
    t1 = last_rx_cyc;
    run_frame(8'hFE, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0);
    chk("b2b_spacing", last_rx_cyc - t1, 37);
    run_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8'h00, 20, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready_low", tx_ready, 0);
    @(posedge clk);
    #1 chk("abort_ready_rise", tx_ready, 1);
    rv = 0;
    repeat (40) begin
      @(negedge clk);
      if (rx_valid) rv++;
    end
    chk("abort_no_rx", rv, 0);
    run_frame(8'hC3, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0);
    run_frame(8'h96, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter HALF_DIV, default 2, clk cycles per sck half-period (legal range 1..255).
REQ-002 Parameter DATA_W, default 8, bits per frame.
REQ-003 clk  in  1  system clock; all logic rising-edge clocked.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cpol  in  1  sck idle level; sampled at frame accept.
REQ-006 cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at frame accept.
REQ-007 tx_valid  in  1  frame request.
REQ-008 tx_data  in  DATA_W  frame to send, MSB first.
REQ-009 tx_ready  out  1  master can accept a frame.
REQ-010 rx_valid  out  1  one-cycle pulse; rx_data is valid.
REQ-011 rx_data  out  DATA_W  frame received from the slave.
REQ-012 busy  out  1  high from accept until tx_ready reasserts.
REQ-013 sck  out  1  SPI clock to the slave sck.
REQ-014 ena  out  1  active-low slave enable to the slave ena; 1 = deselected.
REQ-015 din  out  1  serial data to the slave din (MOSI).
REQ-016 dout  in  1  serial data from the slave dout (MISO).

Function
REQ-017 FSM states: IDLE, SETUP, XFER, HOLD, GAP; reset state is IDLE.
REQ-018 IDLE: tx_ready=1. An accept occurs when tx_valid&&tx_ready at cycle 0; tx_data, cpol and cpha are latched, and the FSM moves to SETUP.
REQ-019 SETUP: ena=0 from cycle 1; lasts HALF_DIV cycles; then XFER.
REQ-020 XFER: 2*DATA_W sck edges at cycles 1+HALF_DIV*k, k=1..2*DATA_W; odd k is the leading edge, even k the trailing edge.
REQ-021 cpha=0: din=MSB from cycle 1; dout sampled on leading edges; din shifts to the next bit on trailing edges, except the last edge.
REQ-022 cpha=1: din updates to the next bit (MSB first) on leading edges; dout sampled on trailing edges; din=MSB during SETUP.
REQ-023 HOLD: sck=latched cpol, ena=0 for HALF_DIV cycles after the last edge.
REQ-024 At cycle 1+HALF_DIV*(2*DATA_W+1): ena=1, rx_data updated, rx_valid=1 for exactly one cycle, FSM moves to GAP.
REQ-025 GAP: ena=1 for HALF_DIV cycles; then IDLE with tx_ready=1. Default timing gives ena low cycles 1..34, rx_valid at 35, tx_ready at 37.
REQ-026 IDLE sck equals the registered cpol input (1-cycle lag); din=0 when idle.
REQ-027 Changes to tx_data, cpol or cpha after accept do not affect the frame in flight.
REQ-028 tx_valid while tx_ready=0 is ignored; the requester holds tx_valid until accepted.
REQ-029 Back-to-back frames: deselect gap of HALF_DIV cycles minimum; ena never stays low across frames.
REQ-030 sck, ena and din are driven directly from flops (glitch-free).

Reset
REQ-031 rst_n low, including mid-frame: FSM=IDLE, sck=0, ena=1, din=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, divider and bit counters=0.
REQ-032 tx_ready rises on the first clk edge after rst_n deasserts; a frame aborted by reset is not resumed and gives no rx_valid.

Structure
REQ-033 Shared package spi_pkg holds: state enum spi_state_t, mode struct spi_mode_t {cpol, cpha}, constant SPI_DATA_W=8.
REQ-034 One sub-module, spi_clk_gen, contains the HALF_DIV divider and emits lead_edge/trail_edge strobes; FSM and shift registers stay in spi_master.

Verification
REQ-035 Mode 0, HALF_DIV=2, tx 0xA5, dout looped to din -> rx_data=0xA5 at cycle 35; ena low cycles 1..34; 16 sck edges.
REQ-036 Mode 0 against spi_slave returning bits 1,0,1,1,0,0,1,0 -> rx_data=0xB2; din waveform carries tx 0x3C MSB first.
REQ-037 Mode 3 (cpol=1, cpha=1), tx 0x81, loopback -> sck idles 1, din changes on falling edges, rx_data=0x81.
REQ-038 Two back-to-back frames 0x01, 0xFE -> two rx_valid pulses 37 cycles apart; ena high ≥2 cycles between frames.
REQ-039 rst_n pulsed low at cycle 20 of a frame -> ena=1 and sck=0 immediately; no rx_valid; next accept completes normally.
REQ-040 tx_data and cpol toggled during XFER -> transmitted bits and sck polarity unchanged.
